// File: rtl/luma_pkg.sv
// Shared types and constants for the luma frame-structure controller.
package luma_pkg;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_FWAIT  = 2'd1,
        ST_LINE   = 2'd2,
        ST_HBLANK = 2'd3
    } luma_state_e;

    localparam int ERR_LEN  = 0;
    localparam int ERR_SYNC = 1;
    localparam int ERR_OVF  = 2;

    localparam int LUMA_MAX_W = 2048;
    localparam int LUMA_MAX_H = 2048;

endpackage

// File: rtl/luma_edge_det.sv
// Registered rise/fall detector: compares the live input with its value one cycle earlier.
module luma_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/luma_frame_ctrl.sv
// Frame-structure controller: tracks dv/hs/vs, numbers pixels, measures frame size,
// gates an ROI and flags malformed frames. One registered stage, latency 1.
module luma_frame_ctrl
    import luma_pkg::*;
#(
    parameter int  MAX_W = LUMA_MAX_W,
    parameter int  MAX_H = LUMA_MAX_H,
    localparam int XW    = $clog2(MAX_W),
    localparam int YW    = $clog2(MAX_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    y_i,
    input  logic          dv_i,
    input  logic          hs_i,
    input  logic          vs_i,
    input  logic [XW-1:0] roi_x0_i,
    input  logic [XW-1:0] roi_x1_i,
    input  logic [YW-1:0] roi_y0_i,
    input  logic [YW-1:0] roi_y1_i,
    output logic [7:0]    y_o,
    output logic          dv_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] row_o,
    output logic          roi_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          eof_o,
    output logic [XW:0]   width_o,
    output logic [YW:0]   height_o,
    output logic          meas_valid_o,
    output logic [2:0]    err_o,
    output logic [1:0]    dbg_state_o
);

    localparam logic [1:0] S_SEEK   = 2'(ST_SEEK);
    localparam logic [1:0] S_FWAIT  = 2'(ST_FWAIT);
    localparam logic [1:0] S_LINE   = 2'(ST_LINE);
    localparam logic [1:0] S_HBLANK = 2'(ST_HBLANK);

    localparam logic [XW:0]   CNT_SAT  = (XW+1)'(MAX_W);
    localparam logic [YW:0]   LINE_SAT = (YW+1)'(MAX_H);
    localparam logic [XW-1:0] X_LAST   = XW'(MAX_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(MAX_H - 1);

    logic dv_rise, dv_fall, vs_rise, unused_vs_fall;

    luma_edge_det u_dv_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (dv_i),
        .rise_o (dv_rise),
        .fall_o (dv_fall)
    );

    luma_edge_det u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vs_i),
        .rise_o (vs_rise),
        .fall_o (unused_vs_fall)
    );

    logic [1:0]    state_q, state_d;
    logic [XW:0]   cnt_q, cnt_d;       // pixels seen in the current line, saturating at MAX_W
    logic [YW:0]   lines_q, lines_d;   // completed lines in the current frame
    logic [XW:0]   fw_q, fw_d;         // length of the first line of the frame
    logic [XW-1:0] rx0_q, rx1_q;
    logic [YW-1:0] ry0_q, ry1_q;
    logic [2:0]    err_q, err_d;
    logic [XW:0]   width_q, width_d;
    logic [YW:0]   height_q, height_d;
    logic          meas_q, meas_d;

    logic [7:0]    yo_q;
    logic          dvo_q, hso_q, vso_q, roio_q, sof_q, eol_q, eof_q;
    logic [XW-1:0] xo_q;
    logic [YW-1:0] rowo_q;

    logic          in_frame, pix, line_end, roi_hit;
    logic          ev_len, ev_sync, ev_ovf;
    logic [XW-1:0] col;
    logic [YW-1:0] row;

    always_comb begin
        in_frame = (state_q != S_SEEK);
        // vs_rise overrides dv: a pixel or line end on that cycle belongs to no frame
        pix      = !vs_rise && dv_i &&
                   ((state_q == S_LINE) ||
                    (((state_q == S_FWAIT) || (state_q == S_HBLANK)) && dv_rise));
        line_end = !vs_rise && (state_q == S_LINE) && dv_fall;

        col = '0;
        if (state_q == S_LINE) begin
            col = (cnt_q >= CNT_SAT) ? X_LAST : cnt_q[XW-1:0];
        end
        row = (lines_q >= LINE_SAT) ? Y_LAST : lines_q[YW-1:0];

        roi_hit = pix && (col >= rx0_q) && (col <= rx1_q) &&
                  (row >= ry0_q) && (row <= ry1_q);

        ev_len  = line_end && (lines_q != '0) && (cnt_q != fw_q);
        ev_sync = vs_rise && dv_i;
        ev_ovf  = (pix && (state_q == S_LINE) && (cnt_q == CNT_SAT)) ||
                  (line_end && (lines_q == LINE_SAT));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lines_d  = lines_q;
        fw_d     = fw_q;
        err_d    = err_q;
        width_d  = width_q;
        height_d = height_q;
        meas_d   = meas_q;

        err_d[ERR_LEN]  = err_q[ERR_LEN]  | ev_len;
        err_d[ERR_SYNC] = err_q[ERR_SYNC] | ev_sync;
        err_d[ERR_OVF]  = err_q[ERR_OVF]  | ev_ovf;

        if (pix) begin
            if (state_q != S_LINE) begin
                cnt_d = {{XW{1'b0}}, 1'b1};
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (line_end) begin
            if (lines_q != LINE_SAT) begin
                lines_d = lines_q + 1'b1;
            end
            if (lines_q == '0) begin
                fw_d = cnt_q;
            end
        end

        case (state_q)
            S_FWAIT:  if (dv_rise) state_d = S_LINE;
            S_LINE:   if (dv_fall) state_d = S_HBLANK;
            S_HBLANK: if (dv_rise) state_d = S_LINE;
            default:  state_d = state_q;
        endcase

        if (vs_rise) begin
            state_d = S_FWAIT;
            cnt_d   = '0;
            lines_d = '0;
            fw_d    = '0;
            err_d   = {ev_ovf, ev_sync, ev_len};
            if (in_frame) begin
                width_d  = fw_q;
                height_d = lines_q;
                meas_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_SEEK;
            cnt_q    <= '0;
            lines_q  <= '0;
            fw_q     <= '0;
            rx0_q    <= '0;
            rx1_q    <= '0;
            ry0_q    <= '0;
            ry1_q    <= '0;
            err_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            meas_q   <= 1'b0;
            yo_q     <= '0;
            dvo_q    <= 1'b0;
            hso_q    <= 1'b0;
            vso_q    <= 1'b0;
            xo_q     <= '0;
            rowo_q   <= '0;
            roio_q   <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lines_q  <= lines_d;
            fw_q     <= fw_d;
            err_q    <= err_d;
            width_q  <= width_d;
            height_q <= height_d;
            meas_q   <= meas_d;
            if (vs_rise) begin
                rx0_q <= roi_x0_i;
                rx1_q <= roi_x1_i;
                ry0_q <= roi_y0_i;
                ry1_q <= roi_y1_i;
            end
            yo_q   <= y_i;
            hso_q  <= hs_i;
            vso_q  <= vs_i;
            dvo_q  <= pix;
            roio_q <= roi_hit;
            if (pix) begin
                xo_q   <= col;
                rowo_q <= row;
            end
            sof_q <= vs_rise;
            eof_q <= vs_rise && in_frame;
            eol_q <= line_end;
        end
    end

    assign y_o          = yo_q;
    assign dv_o         = dvo_q;
    assign hs_o         = hso_q;
    assign vs_o         = vso_q;
    assign x_o          = xo_q;
    assign row_o        = rowo_q;
    assign roi_o        = roio_q;
    assign sof_o        = sof_q;
    assign eol_o        = eol_q;
    assign eof_o        = eof_q;
    assign width_o      = width_q;
    assign height_o     = height_q;
    assign meas_valid_o = meas_q;
    assign err_o        = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_luma_frame_ctrl.sv
// Directed bench for luma_frame_ctrl with small MAX_W/MAX_H so saturation is reachable.
module tb_luma_frame_ctrl;

    localparam int MAX_W = 8;
    localparam int MAX_H = 8;
    localparam int XW    = $clog2(MAX_W);
    localparam int YW    = $clog2(MAX_H);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    y_i = '0;
    logic          dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [XW-1:0] roi_x0_i = '0, roi_x1_i = '0;
    logic [YW-1:0] roi_y0_i = '0, roi_y1_i = '0;
    logic [7:0]    y_o;
    logic          dv_o, hs_o, vs_o, roi_o, sof_o, eol_o, eof_o, meas_valid_o;
    logic [XW-1:0] x_o;
    logic [YW-1:0] row_o;
    logic [XW:0]   width_o;
    logic [YW:0]   height_o;
    logic [2:0]    err_o;
    logic [1:0]    dbg_state_o;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] roi_map     = '0;

    always #5 clk = ~clk;

    luma_frame_ctrl #(.MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
        .clk          (clk),
        .rst          (rst),
        .y_i          (y_i),
        .dv_i         (dv_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .roi_x0_i     (roi_x0_i),
        .roi_x1_i     (roi_x1_i),
        .roi_y0_i     (roi_y0_i),
        .roi_y1_i     (roi_y1_i),
        .y_o          (y_o),
        .dv_o         (dv_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .x_o          (x_o),
        .row_o        (row_o),
        .roi_o        (roi_o),
        .sof_o        (sof_o),
        .eol_o        (eol_o),
        .eof_o        (eof_o),
        .width_o      (width_o),
        .height_o     (height_o),
        .meas_valid_o (meas_valid_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle; outputs sampled 1 ns after the edge belong to that cycle.
    task automatic cyc(input logic dv, input logic hs, input logic vs, input logic [7:0] y);
        dv_i = dv;
        hs_i = hs;
        vs_i = vs;
        y_i  = y;
        @(posedge clk);
        #1;
    endtask

    task automatic pix_line(input int n, input int row);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(16 * row + i));
            chk("dv_o", dv_o, 1);
            chk("x_o", x_o, (i < MAX_W) ? i : MAX_W - 1);
            chk("row_o", row_o, row);
            chk("y_o", y_o, 32'(8'(16 * row + i)));
            if (roi_o) roi_map[int'(row_o) * 8 + int'(x_o)] = 1'b1;
        end
    endtask

    task automatic blank_eol();
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("eol_o", eol_o, 1);
        chk("dv_o_blank", dv_o, 0);
        chk("hs_o", hs_o, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dv_o", dv_o, 0);
        chk("rst_sof_o", sof_o, 0);
        chk("rst_eof_o", eof_o, 0);
        chk("rst_eol_o", eol_o, 0);
        chk("rst_width_o", width_o, 0);
        chk("rst_height_o", height_o, 0);
        chk("rst_meas_valid_o", meas_valid_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_state", dbg_state_o, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("seek_state", dbg_state_o, 0);

        // 4x3 frame with ROI x 1..2, row 1
        roi_x0_i = 3'd1; roi_x1_i = 3'd2; roi_y0_i = 3'd1; roi_y1_i = 3'd1;
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("f1_sof_o", sof_o, 1);
        chk("f1_eof_o", eof_o, 0);
        chk("f1_vs_o", vs_o, 1);
        chk("f1_state", dbg_state_o, 1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("f1_sof_o_low", sof_o, 0);
        for (int r = 0; r < 3; r++) begin
            pix_line(4, r);
            blank_eol();
        end
        chk("f1_err_o", err_o, 0);
        chk("f1_meas_valid_o", meas_valid_o, 0);
        chk("f1_roi_map", roi_map[31:0], 32'h0000_0600);
        chk("f1_roi_map_hi", roi_map[63:32], 0);

        // Second vs_rise closes frame 1; empty ROI for frame 2
        roi_x0_i = 3'd5; roi_x1_i = 3'd2; roi_y0_i = 3'd0; roi_y1_i = 3'd7;
        roi_map = '0;
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("f2_sof_o", sof_o, 1);
        chk("f2_eof_o", eof_o, 1);
        chk("f2_width_o", width_o, 4);
        chk("f2_height_o", height_o, 3);
        chk("f2_meas_valid_o", meas_valid_o, 1);
        chk("f2_err_o", err_o, 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("f2_eof_o_low", eof_o, 0);
        chk("f2_width_hold", width_o, 4);

        // Line lengths 4,4,3
        pix_line(4, 0);
        blank_eol();
        chk("len_err_l0", err_o, 0);
        pix_line(4, 1);
        blank_eol();
        chk("len_err_l1", err_o, 0);
        pix_line(3, 2);
        blank_eol();
        chk("len_err_l2", err_o, 3'b001);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("len_err_sticky", err_o, 3'b001);
        chk("f2_roi_map", roi_map[31:0], 0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("f3_sof_o", sof_o, 1);
        chk("f3_err_cleared", err_o, 0);
        chk("f3_width_o", width_o, 4);
        chk("f3_height_o", height_o, 3);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // vs_rise while dv_i=1 aborts the line
        pix_line(2, 0);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("abort_sof_o", sof_o, 1);
        chk("abort_eof_o", eof_o, 1);
        chk("abort_eol_o", eol_o, 0);
        chk("abort_dv_o", dv_o, 0);
        chk("abort_err_o", err_o, 3'b010);
        chk("abort_height_o", height_o, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("abort_ignored_dv_o", dv_o, 0);
        chk("abort_sof_low", sof_o, 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("abort_no_eol", eol_o, 0);
        chk("abort_err_hold", err_o, 3'b010);
        pix_line(3, 0);
        blank_eol();
        chk("after_abort_err", err_o, 3'b010);

        // 10-pixel line against MAX_W=8
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            chk("ovf_x_o", x_o, (i < 8) ? i : 7);
            chk("ovf_row_o", row_o, 1);
            chk("ovf_err_o", err_o, (i < 8) ? 3'b010 : 3'b110);
        end
        blank_eol();
        chk("ovf_eol_err", err_o, 3'b111);

        // Reset in the middle of a line
        pix_line(2, 2);
        dv_i = 1'b1;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_dv_o", dv_o, 0);
        chk("mid_rst_width_o", width_o, 0);
        chk("mid_rst_height_o", height_o, 0);
        chk("mid_rst_meas", meas_valid_o, 0);
        chk("mid_rst_err_o", err_o, 0);
        chk("mid_rst_state", dbg_state_o, 0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'h5a);
        chk("seek_dv_o", dv_o, 0);
        chk("seek_x_o", x_o, 0);
        chk("seek_y_o", y_o, 32'h5a);
        chk("seek_roi_o", roi_o, 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("seek_eol_o", eol_o, 0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("r_sof_o", sof_o, 1);
        chk("r_eof_o", eof_o, 0);
        chk("r_width_o", width_o, 0);
        chk("r_meas", meas_valid_o, 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        pix_line(2, 0);
        blank_eol();
        pix_line(2, 1);
        blank_eol();
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("r2_sof_o", sof_o, 1);
        chk("r2_eof_o", eof_o, 1);
        chk("r2_width_o", width_o, 2);
        chk("r2_height_o", height_o, 2);
        chk("r2_meas", meas_valid_o, 1);
        chk("r2_err_o", err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/luma_frame_ctrl.md
# luma_frame_ctrl

Frame-structure controller for the luma stream produced by the RGB-to-luma stage. It tracks dv/hs/vs, generates pixel coordinates, measures active width and height, and gates a configurable region of interest (ROI) for downstream statistics blocks. It also flags malformed frames. It is a one-cycle registered stage inserted directly after the luma converter.

## Interface
- MAX_W, default 2048: maximum active pixels per line. XW = $clog2(MAX_W).
- MAX_H, default 2048: maximum active lines per frame. YW = $clog2(MAX_H).
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- y_i  in  8  luma sample
- dv_i / hs_i / vs_i  in  1 each  data valid / hsync / vsync from the luma stage
- roi_x0_i, roi_x1_i  in  XW each  ROI column bounds, inclusive
- roi_y0_i, roi_y1_i  in  YW each  ROI row bounds, inclusive
- y_o  out  8  delayed luma
- dv_o / hs_o / vs_o  out  1 each  delayed syncs
- x_o  out  XW  column of the current dv_o pixel
- row_o  out  YW  row of the current dv_o pixel
- roi_o  out  1  dv_o AND pixel inside the ROI
- sof_o / eol_o / eof_o  out  1 each  start-of-frame / end-of-line / end-of-frame pulses
- width_o  out  XW+1  measured active width of the last complete frame
- height_o  out  YW+1  measured line count of the last complete frame
- meas_valid_o  out  1  width_o and height_o hold at least one complete frame
- err_o  out  3  sticky error flags: [0] line-length mismatch, [1] sync error, [2] counter overflow

## Operation
- Edge detection uses registered copies dv_q and vs_q.
  - vs_rise = vs_i & ~vs_q
  - dv_rise = dv_i & ~dv_q
  - dv_fall = ~dv_i & dv_q
- States:
  - SEEK: after reset. Ignores dv and waits for vs_rise. Exits to FWAIT.
  - FWAIT: frame open, no line seen yet. dv_rise goes to LINE.
  - LINE: dv high. dv_fall goes to HBLANK.
  - HBLANK: between lines. dv_rise goes to LINE.
  - vs_rise in FWAIT, LINE or HBLANK returns to FWAIT (new frame).
- vs_rise handling:
  - Pulses sof_o.
  - Shadows the four ROI bounds; they stay constant for the whole frame.
  - Clears err_o, then ORs in any error event from the same cycle.
  - Clears the row and line counters.
  - Outside SEEK it also pulses eof_o and loads width_o and height_o. meas_valid_o is set from then on.
- Column counter x:
  - Reset to 0 on dv_rise.
  - Incremented on each dv_i pixel after that.
  - Saturates at MAX_W-1 and sets err[2].
- Row counter:
  - Incremented on each dv_fall.
  - The row reported with a pixel is the number of completed lines in the frame.
  - Saturates at MAX_H-1 and sets err[2].
- Line length:
  - The first line's length is latched as the frame width.
  - Any later line of different length sets err[0].
- vs_rise while dv_i=1:
  - Sets err[1], then err is cleared for the new frame. The same-cycle event survives, so err[1]=1 in the new frame.
  - The aborted line gives no eol_o and is not counted.
  - The new frame starts in FWAIT; pixels are ignored until the next dv_rise.
- roi_o = dv_o & x0<=x<=x1 & y0<=row<=y1. If x0>x1 or y0>y1, roi_o never asserts.
- In SEEK, dv_o, roi_o and all pulses are 0. y_o and the syncs still pass through.

## Timing
- Latency from input to every output is 1 cycle. All outputs are registered.
- Input cycle n produces output cycle n+1:
  - dv_i pixel at n gives dv_o, x_o, row_o and roi_o at n+1.
  - dv_fall at n gives eol_o at n+1 (dv_o=0 that cycle).
  - vs_rise at n gives sof_o, and eof_o when applicable, at n+1. width_o and height_o update at n+1.
- Reset values:
  - All outputs 0; width_o = height_o = 0; meas_valid_o = 0; state SEEK.
  - Reset mid-line discards all partial measurement.
- Back-to-back lines (dv low for a single cycle) are legal: eol_o at n+1, next pixel at n+2 with x=0.

## Structure
- luma_pkg holds:
  - state enum (SEEK, FWAIT, LINE, HBLANK)
  - error bit indices ERR_LEN=0, ERR_SYNC=1, ERR_OVF=2
  - default MAX_W and MAX_H
- One sub-module, luma_edge_det: registered rise/fall detector. Instantiated for dv and vs.

## Test plan
- 4x3 frame, then a second vs_rise:
  - x_o runs 0..3 on each of rows 0..2.
  - eol_o pulses three times per frame.
  - eof_o, width_o=4 and height_o=3 appear with the second sof_o; meas_valid_o=1.
  - err_o=0.
- ROI x0=1, x1=2, y0=1, y1=1 on the 4x3 frame: roi_o is high for exactly 2 pixels, at row 1, x=1 and x=2.
- Line lengths 4,4,3: err_o[0]=1 from the third eol_o until the next sof_o. Reported width_o=4.
- vs_rise while dv_i=1:
  - err_o[1]=1 and sof_o fires; no eol_o for the aborted line.
  - Next dv_rise starts at x=0, row 0.
- MAX_W=8, line of 10 pixels: x_o saturates at 7 and err_o[2]=1.
- Reset mid-line, then a 2x2 frame: outputs are 0 until sof_o. Second sof_o reports width_o=2 and height_o=2, with no stale data.
